player_mover: RTL and testbench
===============================

PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 SHALL have parameter STEP, default 2, pixels moved per accepted tick.
REQ-002 SHALL have parameter SPRITE_W, default 32, player bounding-box width in pixels.
REQ-003 SHALL have parameter SPRITE_H, default 32, player bounding-box height in pixels.
REQ-004 SHALL have parameter START_X, default 640, reset x position (top-left corner).
REQ-005 SHALL have parameter START_Y, default 384, reset y position (top-left corner).
REQ-006 SHALL have parameter LOOKUP_LAT, default 1, cycles from query_x/query_y change to a valid walkable input.
REQ-007 clk  in  1  single system clock; all state on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 tick  in  1  one-cycle frame-rate move request.
REQ-010 btn_up, btn_down, btn_left, btn_right  in  1 each  direction buttons, already synchronised.
REQ-011 walkable  in  1  collision lookup result for query_x/query_y, from the downstream collision mask.
REQ-012 query_x  out  11  pixel x sent to the collision mask.
REQ-013 query_y  out  10  pixel y sent to the collision mask.
REQ-014 pos_x  out  11  committed player x.
REQ-015 pos_y  out  10  committed player y.
REQ-016 busy  out  1  high from tick acceptance until done.
REQ-017 done  out  1  one-cycle pulse ending every accepted move attempt.
REQ-018 blocked  out  1  valid with done; 1 means the move was rejected.

Function
REQ-019 FSM states SHALL be IDLE, CALC, QUERY, WAIT, COMMIT, REJECT.
REQ-020 IDLE: a tick with no button pressed SHALL be ignored; a tick with at least one button pressed SHALL move the FSM to CALC and set busy.
REQ-021 Direction priority SHALL be up > down > left > right; only one axis moves per tick.
REQ-022 CALC SHALL form the candidate position (cx,cy) = pos -/+ STEP on the chosen axis.
REQ-023 Bounds check: a candidate with cx<0, cy<0, cx+SPRITE_W>1280 or cy+SPRITE_H>800 SHALL go directly to REJECT, with no query issued.
REQ-024 QUERY SHALL drive corners in order: 0=(cx,cy), 1=(cx+W-1,cy), 2=(cx,cy+H-1), 3=(cx+W-1,cy+H-1).
REQ-025 WAIT SHALL hold the query for LOOKUP_LAT cycles, then sample walkable.
REQ-026 Sampled walkable=0 SHALL go to REJECT immediately; remaining corners are skipped.
REQ-027 Sampled walkable=1 with corner<3 SHALL advance to the next corner in QUERY; walkable=1 on corner 3 SHALL go to COMMIT.
REQ-028 COMMIT SHALL load pos with the candidate, pulse done with blocked=0, and return to IDLE.
REQ-029 REJECT SHALL leave pos unchanged, pulse done with blocked=1, and return to IDLE.
REQ-030 Full-success latency: done SHALL assert 2+4*(LOOKUP_LAT+1) cycles after the tick edge (10 at default).
REQ-031 tick while busy SHALL be ignored (not queued); button changes while busy SHALL not alter the in-flight attempt.
REQ-032 Arithmetic SHALL use 12-bit signed intermediates so underflow and overflow are detected, never wrapped.
REQ-033 While idle, query_x/query_y SHALL equal pos_x/pos_y.

Reset
REQ-034 On rst: pos=(START_X,START_Y), query=(START_X,START_Y), busy=0, done=0, blocked=0, state=IDLE.
REQ-035 rst asserted mid-attempt SHALL abort the attempt with no done pulse and restore pos to the start position.

Structure
REQ-036 Package board_pkg SHALL hold TILE_W/H=32, NUM_TILES_X=40, NUM_TILES_Y=25, SCREEN_W=1280, SCREEN_H=800, dir_t enum {UP,DOWN,LEFT,RIGHT}, and the FSM state typedef.
REQ-037 No sub-module SHALL be used; the collision mask is instantiated beside this block at the top level.

Verification (LOOKUP_LAT=1, registered walkable model)
REQ-038 Reset release -> pos=(640,384), done=0, busy=0.
REQ-039 tick+btn_right, all walkable -> done at cycle 10, blocked=0, pos_x=642.
REQ-040 tick+btn_down, model returns 0 at (640,417) (corner 2) -> done at cycle 8, blocked=1, pos unchanged.
REQ-041 pos_x=1247, tick+btn_right -> REJECT with no query issued, done at cycle 2, blocked=1.
REQ-042 btn_up+btn_left held, tick -> pos_y=382, pos_x unchanged; a second tick at cycle 3 is ignored.
REQ-043 rst pulse at cycle 5 of an attempt -> no done pulse, pos=(640,384).

Source files
------------

// File: rtl/board_pkg.sv
// board_pkg
// Shared board geometry, movement direction encoding and the player FSM
// state encoding. Imported by player_mover and by the top level that places
// the collision mask beside it.
package board_pkg;

  localparam int TILE_W      = 32;
  localparam int TILE_H      = 32;
  localparam int NUM_TILES_X = 40;
  localparam int NUM_TILES_Y = 25;
  localparam int SCREEN_W    = 1280;
  localparam int SCREEN_H    = 800;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  // Plain vector states so they can be compared and stored like the older
  // controllers that consume this package.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CALC   = 3'd1;
  localparam state_t ST_QUERY  = 3'd2;
  localparam state_t ST_WAIT   = 3'd3;
  localparam state_t ST_COMMIT = 3'd4;
  localparam state_t ST_REJECT = 3'd5;

endpackage

// File: rtl/player_mover.sv
// player_mover
// Moves the player's bounding box by STEP pixels per accepted frame tick.
// Each attempt is bounds-checked against the screen, then the four corners of
// the candidate box are looked up in the external collision mask one at a
// time; the move is committed only if every corner is walkable.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   tick                     one-cycle move request (ignored while busy)
//   btn_up/down/left/right   synchronised direction buttons
//   walkable                 collision mask answer for query_x/query_y
//   query_x, query_y         pixel sent to the collision mask
//   pos_x, pos_y             committed top-left player position
//   busy                     attempt in flight
//   done, blocked            end-of-attempt pulse and its reject flag
//
// state   | meaning
// IDLE    | waiting for a tick with a button held; query follows pos
// CALC    | form candidate position and bounds-check it
// QUERY   | present the current corner to the collision mask
// WAIT    | hold the corner for LOOKUP_LAT cycles, then sample walkable
// COMMIT  | load pos with the candidate, pulse done
// REJECT  | keep pos, pulse done with blocked
module player_mover
  import board_pkg::*;
#(
  parameter int STEP       = 2,
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int START_X    = 640,
  parameter int START_Y    = 384,
  parameter int LOOKUP_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        walkable,
  output logic [10:0] query_x,
  output logic [9:0]  query_y,
  output logic [10:0] pos_x,
  output logic [9:0]  pos_y,
  output logic        busy,
  output logic        done,
  output logic        blocked
);

  localparam int WAIT_W    = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
  localparam int WAIT_LOAD = (LOOKUP_LAT > 0) ? LOOKUP_LAT - 1 : 0;

  localparam logic signed [11:0] STEP_S  = 12'(STEP);
  localparam logic signed [12:0] SW_S    = 13'(SPRITE_W);
  localparam logic signed [12:0] SH_S    = 13'(SPRITE_H);
  localparam logic signed [12:0] SCR_W_S = 13'(SCREEN_W);
  localparam logic signed [12:0] SCR_H_S = 13'(SCREEN_H);
  localparam logic [10:0]        X_OFF   = 11'(SPRITE_W - 1);
  localparam logic [9:0]         Y_OFF   = 10'(SPRITE_H - 1);

  state_t              state;
  dir_t                dir_q;
  dir_t                pick_dir;
  logic [1:0]          corner;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [10:0]         cx_q;
  logic [9:0]          cy_q;

  logic                any_btn;
  logic signed [11:0]  px_s, py_s;
  logic signed [11:0]  cand_x, cand_y;
  logic signed [12:0]  cand_x_w, cand_y_w;
  logic                out_of_bounds;
  state_t              sample_state;
  logic                in_lookup;

  assign any_btn = btn_up | btn_down | btn_left | btn_right;

  always_comb begin
    if (btn_up)        pick_dir = UP;
    else if (btn_down) pick_dir = DOWN;
    else if (btn_left) pick_dir = LEFT;
    else               pick_dir = RIGHT;
  end

  // Signed 12-bit candidate so a step past 0 goes negative instead of
  // wrapping; the right/bottom edge test is widened once more so the sum
  // with the sprite size cannot overflow either.
  assign px_s = signed'({1'b0, pos_x});
  assign py_s = signed'({2'b00, pos_y});

  always_comb begin
    cand_x = px_s;
    cand_y = py_s;
    case (dir_q)
      UP:      cand_y = py_s - STEP_S;
      DOWN:    cand_y = py_s + STEP_S;
      LEFT:    cand_x = px_s - STEP_S;
      default: cand_x = px_s + STEP_S;
    endcase
  end

  assign cand_x_w = {cand_x[11], cand_x};
  assign cand_y_w = {cand_y[11], cand_y};

  assign out_of_bounds = (cand_x < 12'sd0) || (cand_y < 12'sd0) ||
                         ((cand_x_w + SW_S) > SCR_W_S) ||
                         ((cand_y_w + SH_S) > SCR_H_S);

  // First non-walkable corner aborts; the rest are never looked up.
  always_comb begin
    if (!walkable)          sample_state = ST_REJECT;
    else if (corner == 2'd3) sample_state = ST_COMMIT;
    else                    sample_state = ST_QUERY;
  end

  // Corner bit 0 selects the right edge, bit 1 the bottom edge.
  assign in_lookup = (state == ST_QUERY) || (state == ST_WAIT);
  assign query_x   = in_lookup ? (corner[0] ? cx_q + X_OFF : cx_q) : pos_x;
  assign query_y   = in_lookup ? (corner[1] ? cy_q + Y_OFF : cy_q) : pos_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      dir_q    <= UP;
      corner   <= 2'd0;
      wait_cnt <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      pos_x    <= 11'(START_X);
      pos_y    <= 10'(START_Y);
      busy     <= 1'b0;
      done     <= 1'b0;
      blocked  <= 1'b0;
    end else begin
      done    <= 1'b0;
      blocked <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick && any_btn) begin
            dir_q <= pick_dir;
            busy  <= 1'b1;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          // Only the low bits are kept; they are exact whenever the bounds
          // check passes, and unused otherwise.
          cx_q   <= cand_x[10:0];
          cy_q   <= cand_y[9:0];
          corner <= 2'd0;
          state  <= out_of_bounds ? ST_REJECT : ST_QUERY;
        end
        ST_QUERY: begin
          if (LOOKUP_LAT == 0) begin
            corner <= corner + 2'd1;
            state  <= sample_state;
          end else begin
            wait_cnt <= WAIT_W'(WAIT_LOAD);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            corner <= corner + 2'd1;
            state  <= sample_state;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_COMMIT: begin
          pos_x <= cx_q;
          pos_y <= cy_q;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_REJECT: begin
          done    <= 1'b1;
          blocked <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_mover.sv
// tb_player_mover
// Directed moves on a default-parameter player_mover with a registered
// collision-mask model, plus a second instance started at the screen corner
// (1247,0) for the edge cases. Expected results are queued at the tick and
// checked by a monitor when done pulses.
module tb_player_mover;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, bu, bd, bl, br;
  logic        walkable;
  logic [10:0] query_x, pos_x;
  logic [9:0]  query_y, pos_y;
  logic        busy, done, blocked;

  logic        e_tick, e_bu, e_bd, e_bl, e_br;
  logic        e_walkable;
  logic [10:0] e_query_x, e_pos_x;
  logic [9:0]  e_query_y, e_pos_y;
  logic        e_busy, e_done, e_blocked;

  always #5 clk = ~clk;

  player_mover #(.LOOKUP_LAT(1)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_up(bu), .btn_down(bd), .btn_left(bl), .btn_right(br),
    .walkable(walkable), .query_x(query_x), .query_y(query_y),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .done(done), .blocked(blocked)
  );

  player_mover #(.START_X(1247), .START_Y(0), .LOOKUP_LAT(1)) dut_edge (
    .clk(clk), .rst(rst), .tick(e_tick),
    .btn_up(e_bu), .btn_down(e_bd), .btn_left(e_bl), .btn_right(e_br),
    .walkable(e_walkable), .query_x(e_query_x), .query_y(e_query_y),
    .pos_x(e_pos_x), .pos_y(e_pos_y), .busy(e_busy), .done(e_done),
    .blocked(e_blocked)
  );

  typedef struct {
    logic blk;
    int   x;
    int   y;
    int   lat;
    int   t0;
    bit   q;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          dn_cnt = 0;
  bit          q_seen = 0;
  logic        blk_en;
  logic [10:0] bad_x;
  logic [9:0]  bad_y;

  always @(posedge clk) cyc <= cyc + 1;

  // Collision mask: one registered cycle of lookup latency, one bad pixel.
  always @(posedge clk)
    walkable <= !(blk_en && query_x == bad_x && query_y == bad_y);

  assign e_walkable = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q_seen = 0;
    end else begin
      if (busy && (query_x != pos_x || query_y != pos_y)) q_seen = 1;
      if (done) begin
        dn_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          cur = sb.pop_front();
          chk("blocked", int'(blocked), int'(cur.blk));
          chk("pos_x", int'(pos_x), cur.x);
          chk("pos_y", int'(pos_y), cur.y);
          chk("latency", cyc - cur.t0, cur.lat);
          chk("query_issued", int'(q_seen), int'(cur.q));
        end
        q_seen = 0;
      end
    end
  end

  // b = {up, down, left, right}
  task automatic attempt(input logic [3:0] b, input logic eb, input int ex,
                         input int ey, input int elat, input int tick2_at,
                         input logic [3:0] b2, input int b2_at);
    exp_t e;
    bit   fin = 0;
    @(negedge clk);
    {bu, bd, bl, br} = b;
    tick = 1'b1;
    @(posedge clk);
    #1;
    e.blk = eb; e.x = ex; e.y = ey; e.lat = elat; e.t0 = cyc; e.q = (elat != 2);
    sb.push_back(e);
    for (int k = 1; k <= 40 && !fin; k++) begin
      @(negedge clk);
      tick = (k == tick2_at);
      if (k == b2_at) {bu, bd, bl, br} = b2;
      #1;
      if (sb.size() == 0) fin = 1;
    end
    tick = 1'b0;
    {bu, bd, bl, br} = 4'b0000;
    if (!fin) begin
      chk("attempt_timeout", sb.size(), 0);
      sb.delete();
    end else begin
      chk("idle_query_x", int'(query_x), ex);
      chk("idle_query_y", int'(query_y), ey);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic edge_attempt(input logic [3:0] b, input logic eb, input int ex,
                              input int ey, input int elat);
    int t0;
    bit fin = 0;
    bit qf = 0;
    @(negedge clk);
    {e_bu, e_bd, e_bl, e_br} = b;
    e_tick = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int k = 1; k <= 30 && !fin; k++) begin
      @(negedge clk);
      e_tick = 1'b0;
      if (e_busy && (e_query_x != e_pos_x || e_query_y != e_pos_y)) qf = 1;
      if (e_done) begin
        chk("edge_latency", cyc - t0, elat);
        chk("edge_blocked", int'(e_blocked), int'(eb));
        chk("edge_pos_x", int'(e_pos_x), ex);
        chk("edge_pos_y", int'(e_pos_y), ey);
        chk("edge_query_issued", int'(qf), int'(elat != 2));
        fin = 1;
      end
    end
    {e_bu, e_bd, e_bl, e_br} = 4'b0000;
    if (!fin) chk("edge_timeout", int'(fin), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    tick = 0; bu = 0; bd = 0; bl = 0; br = 0;
    e_tick = 0; e_bu = 0; e_bd = 0; e_bl = 0; e_br = 0;
    blk_en = 0; bad_x = '0; bad_y = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_pos_x", int'(pos_x), 640);
    chk("rst_pos_y", int'(pos_y), 384);
    chk("rst_query_x", int'(query_x), 640);
    chk("rst_query_y", int'(query_y), 384);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_blocked", int'(blocked), 0);
    chk("rst_edge_pos_x", int'(e_pos_x), 1247);
    chk("rst_edge_pos_y", int'(e_pos_y), 0);

    // down blocked at corner 2 (640,417)
    blk_en = 1; bad_x = 11'd640; bad_y = 10'd417;
    attempt(4'b0100, 1'b1, 640, 384, 8, 0, 4'b0000, 0);
    // right, all walkable
    blk_en = 0;
    attempt(4'b0001, 1'b0, 642, 384, 10, 0, 4'b0000, 0);
    // left blocked at corner 0 (640,384)
    blk_en = 1; bad_x = 11'd640; bad_y = 10'd384;
    attempt(4'b0010, 1'b1, 642, 384, 4, 0, 4'b0000, 0);
    // right blocked at corner 3 (675,415)
    bad_x = 11'd675; bad_y = 10'd415;
    attempt(4'b0001, 1'b1, 642, 384, 10, 0, 4'b0000, 0);
    // up+left: up wins; second tick at cycle 3 is ignored
    blk_en = 0;
    attempt(4'b1010, 1'b0, 642, 382, 10, 3, 4'b0000, 0);
    // right, buttons switch to down mid-attempt: still moves right
    attempt(4'b0001, 1'b0, 644, 382, 10, 0, 4'b0100, 1);

    // reset at cycle 5 of an attempt: no done, back to start
    @(negedge clk);
    bd = 1'b1;
    tick = 1'b1;
    @(posedge clk);
    #1;
    d0 = dn_cnt;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      tick = 1'b0;
      if (k == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    bd = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_mid_done_count", dn_cnt - d0, 0);
    chk("rst_mid_pos_x", int'(pos_x), 640);
    chk("rst_mid_pos_y", int'(pos_y), 384);
    chk("rst_mid_busy", int'(busy), 0);

    // edge instance at (1247,0)
    edge_attempt(4'b0001, 1'b1, 1247, 0, 2);
    edge_attempt(4'b1000, 1'b1, 1247, 0, 2);
    edge_attempt(4'b0010, 1'b0, 1245, 0, 10);
    edge_attempt(4'b0001, 1'b0, 1247, 0, 10);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
